word_serializer: RTL
====================

// Module: word_serializer
// PURPOSE
// - Parallel-to-serial front end for the 1-bit shift delay line: accepts WIDTH-bit words on a valid/ready handshake, emits them MSB-first one bit per clk.
// - ser_out drives the delay line's serial data input directly.
// - ser_valid and frame_start let downstream logic and the bench align frames.
// - Back-to-back words stream with no idle bubble.
// PARAMETERS
// - WIDTH     8   word width in bits; legal range 2..32
// - IDLE_BIT  0   level driven on ser_out when no bit is being sent
// PORTS
// - clk          input   1      clock; all state updates on posedge
// - rst          input   1      reset; asynchronous, active-high
// - in_data      input   WIDTH  parallel word; sampled only when in_valid && in_ready
// - in_valid     input   1      in_data holds a word to send
// - in_ready     output  1      block will accept a word at the next posedge
// - ser_out      output  1      serial bit stream, registered
// - ser_valid    output  1      ser_out carries a frame bit this cycle, registered
// - frame_start  output  1      ser_out carries the first (MSB) bit of a frame, registered
// - busy         output  1      a frame is in progress (state != IDLE), registered
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - state=IDLE, shift reg=0, bit counter=0.
//   - ser_out=IDLE_BIT, ser_valid=0, frame_start=0, busy=0.
//   - in_ready is forced 0 while rst is high.
// - States: IDLE, SHIFT, plus PARITY (PARITY state exists only with SERIALIZER_PARITY_EN).
// - Accept: a word is taken on any posedge where in_valid && in_ready.
// - in_ready (combinational, never depends on in_valid) is 1 when any of these holds:
//   - state==IDLE;
//   - state==SHIFT and cnt==0, parity feature off;
//   - state==PARITY.
// - Latency: word accepted at edge N -> MSB on ser_out, with ser_valid=1 and frame_start=1, in the cycle after edge N.
// - SHIFT:
//   - Registered outputs present bit cnt of the word, for cnt = WIDTH-1 down to 0.
//   - cnt decrements by 1 per clk. cnt width = ceil(log2(WIDTH)), min 1.
//   - ser_valid=1 throughout; frame_start=1 only while cnt==WIDTH-1.
// - Frame end (last bit, or parity bit when enabled):
//   - If a word is accepted at that edge: reload shift reg, cnt=WIDTH-1, remain in SHIFT. The next word's MSB follows with zero gap.
//   - Otherwise: go to IDLE; ser_out=IDLE_BIT, ser_valid=0, busy=0 from the next cycle.
// - in_data changes while not accepted are ignored. The word being shifted is never corrupted by input activity.
// - in_valid dropping mid-frame has no effect on the current frame.
// - rst asserted mid-frame: frame aborted immediately. No partial word is resumed after release.
// - No overflow is possible: the handshake stalls the source.
// CONFIGURATION
// - SERIALIZER_PARITY_EN defined:
//   - After bit 0, one PARITY cycle emits even parity (XOR of all WIDTH bits of the word), with ser_valid=1 and frame_start=0.
//   - Frame length is WIDTH+1 cycles. in_ready=1 in the PARITY cycle and not on bit 0.
// - SERIALIZER_PARITY_EN undefined:
//   - No PARITY state; frame length is WIDTH cycles.
//   - in_ready=1 on the bit-0 cycle.
// TESTING
// - Reset: rst=1 mid-frame -> same cycle ser_valid=0, ser_out=IDLE_BIT, busy=0, in_ready=0; after release in_ready=1.
// - Single word, WIDTH=8, in_data=8'hA5 accepted at edge N -> ser_out 1,0,1,0,0,1,0,1 in cycles N+1..N+8; frame_start only in N+1; then idle.
// - Back-to-back: in_valid held high with 8'hFF then 8'h00 -> 16 contiguous ser_valid cycles, frame_start at cycles 1 and 9, in_ready pulses once per frame.
// - Stall: in_valid=0 for 5 cycles between words -> ser_valid=0 and ser_out=IDLE_BIT during the gap; no spurious frame_start.
// - Parity (macro on): 8'h07 -> nine bits 0,0,0,0,0,1,1,1,1; 8'h03 -> parity bit 0.
// - Chained with delay line: 4 words streamed -> delay-line output equals ser_out delayed by exactly 32 cycles, bit-exact.

Source files
------------

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in on valid/ready, MSB-first bits out, one per clk.
// Define SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module word_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshake: a word transfers on any posedge where in_valid && in_ready.
  // in_ready is a function of state only (never of in_valid) and is held low during rst.

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  // Only the bits still to be sent are kept; the MSB goes straight to ser_out on load.
  logic [WIDTH-2:0] rest, rest_nxt;
  logic             ser_out_nxt, ser_valid_nxt, frame_start_nxt;
  logic             ready_c, accept;
`ifdef SERIALIZER_PARITY_EN
  logic             par, par_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rest        <= '0;
      ser_out     <= IDLE_BIT;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rest        <= rest_nxt;
      ser_out     <= ser_out_nxt;
      ser_valid   <= ser_valid_nxt;
      frame_start <= frame_start_nxt;
`ifdef SERIALIZER_PARITY_EN
      par         <= par_nxt;
`endif
    end
  end

  always_comb begin
    ready_c = 1'b0;
    case (state)
      IDLE:   ready_c = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      PARITY: ready_c = 1'b1;
`else
      SHIFT:  ready_c = (cnt == '0);
`endif
      default: ready_c = 1'b0;
    endcase
    in_ready = ready_c && !rst;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    rest_nxt        = rest;
    ser_out_nxt     = IDLE_BIT;
    ser_valid_nxt   = 1'b0;
    frame_start_nxt = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    par_nxt         = par;
`endif
    if (accept) begin
      // Accept also covers the frame-end reload, giving zero-gap streaming.
      state_nxt       = SHIFT;
      cnt_nxt         = CNT_TOP;
      rest_nxt        = in_data[WIDTH-2:0];
      ser_out_nxt     = in_data[WIDTH-1];
      ser_valid_nxt   = 1'b1;
      frame_start_nxt = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      par_nxt         = ^in_data;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt != '0) begin
            cnt_nxt       = cnt - CW'(1);
            rest_nxt      = rest << 1;
            ser_out_nxt   = rest[WIDTH-2];
            ser_valid_nxt = 1'b1;
          end else begin
`ifdef SERIALIZER_PARITY_EN
            state_nxt     = PARITY;
            ser_out_nxt   = par;
            ser_valid_nxt = 1'b1;
`else
            state_nxt     = IDLE;
`endif
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
